// File: rtl/axi_dma_mem_responder.sv
// AXI4 subordinate backed by a word-addressed storage array; serves DMA backend bursts.
// Independent read and write FSMs share one array, one burst outstanding per channel.

package axi_dma_mem_responder_pkg;
    localparam int unsigned AxiDataWidth = 64;
    localparam int unsigned AxiAddrWidth = 32;
    localparam int unsigned AxiIdWidth   = 4;
    localparam int unsigned AxiUserWidth = 1;
    localparam int unsigned AxiStrbWidth = AxiDataWidth / 8;

    localparam logic [1:0] BurstIncr  = 2'b01;
    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespSlverr = 2'b10;

    typedef struct packed {
        logic [AxiIdWidth-1:0]   id;
        logic [AxiAddrWidth-1:0] addr;
        logic [7:0]              len;
        logic [2:0]              size;
        logic [1:0]              burst;
        logic                    lock;
        logic [3:0]              cache;
        logic [2:0]              prot;
        logic [3:0]              qos;
        logic [3:0]              region;
        logic [5:0]              atop;
        logic [AxiUserWidth-1:0] user;
    } aw_chan_t;

    typedef struct packed {
        logic [AxiDataWidth-1:0] data;
        logic [AxiStrbWidth-1:0] strb;
        logic                    last;
        logic [AxiUserWidth-1:0] user;
    } w_chan_t;

    typedef struct packed {
        logic [AxiIdWidth-1:0]   id;
        logic [1:0]              resp;
        logic [AxiUserWidth-1:0] user;
    } b_chan_t;

    typedef struct packed {
        logic [AxiIdWidth-1:0]   id;
        logic [AxiAddrWidth-1:0] addr;
        logic [7:0]              len;
        logic [2:0]              size;
        logic [1:0]              burst;
        logic                    lock;
        logic [3:0]              cache;
        logic [2:0]              prot;
        logic [3:0]              qos;
        logic [3:0]              region;
        logic [AxiUserWidth-1:0] user;
    } ar_chan_t;

    typedef struct packed {
        logic [AxiIdWidth-1:0]   id;
        logic [AxiDataWidth-1:0] data;
        logic [1:0]              resp;
        logic                    last;
        logic [AxiUserWidth-1:0] user;
    } r_chan_t;

    typedef struct packed {
        aw_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ar_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } axi_req_t;

    typedef struct packed {
        logic    aw_ready;
        logic    ar_ready;
        logic    w_ready;
        logic    b_valid;
        b_chan_t b;
        logic    r_valid;
        r_chan_t r;
    } axi_res_t;
endpackage

module axi_dma_mem_responder #(
    parameter int unsigned DataWidth = 64,
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned IdWidth   = 4,
    parameter int unsigned UserWidth = 1,
    parameter int unsigned MemWords  = 1024,
    parameter type axi_req_t = axi_dma_mem_responder_pkg::axi_req_t,
    parameter type axi_res_t = axi_dma_mem_responder_pkg::axi_res_t
) (
    input  logic     clk_i,
    input  logic     rst_i,
    input  axi_req_t axi_req_i,
    output axi_res_t axi_res_o,
    output logic     busy_o
);
    localparam int unsigned NumBytes = DataWidth / 8;
    localparam int unsigned OffW     = $clog2(NumBytes);
    localparam int unsigned MemAw    = $clog2(MemWords);
    localparam int unsigned HiW      = AddrWidth - OffW - MemAw;

    typedef enum logic {R_IDLE, R_BURST} r_state_e;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;

    logic [DataWidth-1:0] mem [MemWords];

    r_state_e             r_state;
    logic [IdWidth-1:0]   r_id_q;
    logic [AddrWidth-1:0] r_addr_q;
    logic [7:0]           r_len_q;
    logic [7:0]           r_cnt_q;
    logic                 r_err_q;

    w_state_e             w_state;
    logic [IdWidth-1:0]   w_id_q;
    logic [AddrWidth-1:0] w_addr_q;
    logic [7:0]           w_len_q;
    logic [7:0]           w_cnt_q;
    logic                 w_err_q;
    logic                 w_sticky_q;

    logic aw_ready, w_ready, b_valid, ar_ready, r_valid;
    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic r_ok, w_ok, r_last;
    logic ar_err, aw_err;

    // Beat is in range only when every address bit above the word index is zero.
    function automatic logic in_range(input logic [AddrWidth-1:0] addr);
        return addr[AddrWidth-1 -: HiW] == '0;
    endfunction

    // Handshake signals decode from state only; reset forces them low immediately.
    assign ar_ready = !rst_i && (r_state == R_IDLE);
    assign r_valid  = !rst_i && (r_state == R_BURST);
    assign aw_ready = !rst_i && (w_state == W_IDLE);
    assign w_ready  = !rst_i && (w_state == W_DATA);
    assign b_valid  = !rst_i && (w_state == W_RESP);
    assign busy_o   = !rst_i && ((r_state != R_IDLE) || (w_state != W_IDLE));

    assign ar_hs = ar_ready && axi_req_i.ar_valid;
    assign r_hs  = r_valid  && axi_req_i.r_ready;
    assign aw_hs = aw_ready && axi_req_i.aw_valid;
    assign w_hs  = w_ready  && axi_req_i.w_valid;
    assign b_hs  = b_valid  && axi_req_i.b_ready;

    assign ar_err = (axi_req_i.ar.burst != axi_dma_mem_responder_pkg::BurstIncr) ||
                    (axi_req_i.ar.size != 3'(OffW));
    assign aw_err = (axi_req_i.aw.burst != axi_dma_mem_responder_pkg::BurstIncr) ||
                    (axi_req_i.aw.size != 3'(OffW)) || (axi_req_i.aw.atop != '0);

    assign r_ok   = !r_err_q && in_range(r_addr_q);
    assign w_ok   = !w_err_q && in_range(w_addr_q);
    assign r_last = (r_cnt_q == r_len_q);

    always_comb begin
        axi_res_o          = '0;
        axi_res_o.aw_ready = aw_ready;
        axi_res_o.w_ready  = w_ready;
        axi_res_o.ar_ready = ar_ready;
        axi_res_o.b_valid  = b_valid;
        axi_res_o.b.id     = w_id_q;
        axi_res_o.b.resp   = w_sticky_q ? axi_dma_mem_responder_pkg::RespSlverr
                                        : axi_dma_mem_responder_pkg::RespOkay;
        axi_res_o.b.user   = {UserWidth{1'b0}};
        axi_res_o.r_valid  = r_valid;
        axi_res_o.r.id     = r_id_q;
        axi_res_o.r.data   = r_ok ? mem[r_addr_q[OffW +: MemAw]] : '0;
        axi_res_o.r.resp   = r_ok ? axi_dma_mem_responder_pkg::RespOkay
                                  : axi_dma_mem_responder_pkg::RespSlverr;
        axi_res_o.r.last   = r_last;
        axi_res_o.r.user   = {UserWidth{1'b0}};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= R_IDLE;
            r_id_q     <= '0;
            r_addr_q   <= '0;
            r_len_q    <= '0;
            r_cnt_q    <= '0;
            r_err_q    <= 1'b0;
            w_state    <= W_IDLE;
            w_id_q     <= '0;
            w_addr_q   <= '0;
            w_len_q    <= '0;
            w_cnt_q    <= '0;
            w_err_q    <= 1'b0;
            w_sticky_q <= 1'b0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (ar_hs) begin
                        r_id_q   <= axi_req_i.ar.id;
                        r_addr_q <= axi_req_i.ar.addr;
                        r_len_q  <= axi_req_i.ar.len;
                        r_err_q  <= ar_err;
                        r_cnt_q  <= '0;
                        r_state  <= R_BURST;
                    end
                end
                R_BURST: begin
                    if (r_hs) begin
                        if (r_last) begin
                            r_state <= R_IDLE;
                        end else begin
                            r_addr_q <= r_addr_q + AddrWidth'(NumBytes);
                            r_cnt_q  <= r_cnt_q + 8'd1;
                        end
                    end
                end
                default: r_state <= R_IDLE;
            endcase

            case (w_state)
                W_IDLE: begin
                    if (aw_hs) begin
                        w_id_q     <= axi_req_i.aw.id;
                        w_addr_q   <= axi_req_i.aw.addr;
                        w_len_q    <= axi_req_i.aw.len;
                        w_err_q    <= aw_err;
                        w_cnt_q    <= '0;
                        w_sticky_q <= 1'b0;
                        w_state    <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_hs) begin
                        w_addr_q <= w_addr_q + AddrWidth'(NumBytes);
                        w_cnt_q  <= w_cnt_q + 8'd1;
                        // A burst that ends early or late is reported as an error.
                        if (!w_ok || (axi_req_i.w.last && (w_cnt_q != w_len_q))) begin
                            w_sticky_q <= 1'b1;
                        end
                        if (axi_req_i.w.last) begin
                            w_state <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (b_hs) begin
                        w_state <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // Storage is never reset; byte lanes follow w_strb.
    always_ff @(posedge clk_i) begin
        if (w_hs && w_ok) begin
            for (int unsigned b = 0; b < NumBytes; b++) begin
                if (axi_req_i.w.strb[b]) begin
                    mem[w_addr_q[OffW +: MemAw]][b*8 +: 8] <= axi_req_i.w.data[b*8 +: 8];
                end
            end
        end
    end

    logic unused;
    assign unused = ^{axi_req_i.aw.lock, axi_req_i.aw.cache, axi_req_i.aw.prot,
                      axi_req_i.aw.qos, axi_req_i.aw.region, axi_req_i.aw.user,
                      axi_req_i.w.user, axi_req_i.ar.lock, axi_req_i.ar.cache,
                      axi_req_i.ar.prot, axi_req_i.ar.qos, axi_req_i.ar.region,
                      axi_req_i.ar.user, r_addr_q[OffW-1:0], w_addr_q[OffW-1:0]};
endmodule

// File: tb/tb_axi_dma_mem_responder.sv
// Bench for axi_dma_mem_responder: directed vector table, multi-cycle corner sequences,
// and randomized bursts checked against a word-array reference model.
module tb_axi_dma_mem_responder;
    localparam int unsigned MemWords = 1024;
    localparam int TMO = 40;
    localparam logic [1:0] OKAY = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] INCR = 2'b01;
    localparam logic [1:0] FIXED = 2'b00;

    logic clk;
    logic rst;
    logic busy;
    axi_dma_mem_responder_pkg::axi_req_t req;
    axi_dma_mem_responder_pkg::axi_res_t res;

    axi_dma_mem_responder dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .axi_req_i (req),
        .axi_res_o (res),
        .busy_o    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    logic hung = 1'b0;

    logic [63:0] mdl [MemWords];
    logic [63:0] wdata_q[$];
    logic [7:0]  wstrb_q[$];
    logic [63:0] rd_data_q[$];
    logic [1:0]  rd_resp_q[$];

    typedef struct {
        logic [31:0] waddr;
        logic [1:0]  wburst;
        logic [2:0]  wsize;
        logic [5:0]  watop;
        logic [63:0] wdata;
        logic [7:0]  wstrb;
        logic [1:0]  exp_b;
        logic [31:0] raddr;
        logic [1:0]  rburst;
        logic [63:0] exp_r;
        logic [1:0]  exp_rresp;
    } vec_t;

    vec_t vecs[12];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic in_rng(input logic [31:0] a);
        return (a >> 3) < MemWords;
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'(a >> 3);
    endfunction

    function automatic logic res_sig(input int which);
        case (which)
            0: return res.aw_ready;
            1: return res.w_ready;
            2: return res.b_valid;
            3: return res.ar_ready;
            4: return res.r_valid;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_sig(input int which, input string name, output logic ok);
        int n = 0;
        while (!res_sig(which) && !hung && n < TMO) begin
            step();
            n++;
        end
        ok = res_sig(which);
        if (!ok) begin
            hung = 1'b1;
            n_cmp++;
            n_err++;
            $display("FAIL %s: no handshake within %0d cycles", name, TMO);
        end
    endtask

    // Write burst: model applies the spec rules, DUT is driven and its B response checked.
    task automatic axi_write(input logic [31:0] addr, input int len, input logic [3:0] id,
                             input logic [1:0] burst, input logic [2:0] size, input logic [5:0] atop,
                             input int nbeats, input int bstall, output logic [1:0] bresp);
        logic berr, sticky, ok;
        logic [1:0] exp_b;
        logic [31:0] a;
        int beat;
        bresp = 2'b11;
        berr = (burst != INCR) || (size != 3'd3) || (atop != 6'd0);
        sticky = berr || (nbeats != len + 1);
        for (int i = 0; i < nbeats; i++) begin
            a = addr + 32'(i * 8);
            if (berr || !in_rng(a)) sticky = 1'b1;
            else for (int b = 0; b < 8; b++)
                if (wstrb_q[i][b]) mdl[widx(a)][b*8 +: 8] = wdata_q[i][b*8 +: 8];
        end
        exp_b = sticky ? SLVERR : OKAY;

        req.aw = '0;
        req.aw.addr = addr;
        req.aw.len = 8'(len);
        req.aw.id = id;
        req.aw.burst = burst;
        req.aw.size = size;
        req.aw.atop = atop;
        req.aw_valid = 1'b1;
        req.w = '0;
        req.w.data = wdata_q[0];
        req.w.strb = wstrb_q[0];
        req.w.last = (nbeats == 1);
        req.w_valid = 1'b1;
        wait_sig(0, "aw_ready", ok);
        if (!ok) begin req.aw_valid = 1'b0; req.w_valid = 1'b0; return; end
        chk("w_ready_before_aw", res.w_ready, 1'b0);
        step();
        req.aw_valid = 1'b0;
        chk("aw_to_w_ready", {res.w_ready, res.aw_ready, busy}, 3'b101);

        beat = 0;
        while (beat < nbeats) begin
            req.w.data = wdata_q[beat];
            req.w.strb = wstrb_q[beat];
            req.w.last = (beat == nbeats - 1);
            req.w_valid = 1'b1;
            wait_sig(1, "w_ready", ok);
            if (!ok) begin req.w_valid = 1'b0; return; end
            step();
            beat++;
            if (beat < nbeats && $urandom_range(0, 3) == 0) begin
                req.w_valid = 1'b0;
                step();
            end
        end
        req.w_valid = 1'b0;
        chk("b_valid_latency", res.b_valid, 1'b1);
        for (int k = 0; k < bstall; k++) begin
            chk("b_stall_stable", {res.b_valid, res.b.id, res.b.resp, res.aw_ready}, {1'b1, id, exp_b, 1'b0});
            step();
        end
        req.b_ready = 1'b1;
        wait_sig(2, "b_valid", ok);
        if (!ok) begin req.b_ready = 1'b0; return; end
        chk("b_resp", {res.b.id, res.b.resp}, {id, exp_b});
        bresp = res.b.resp;
        step();
        req.b_ready = 1'b0;
        chk("aw_ready_after_b", {res.aw_ready, res.b_valid}, 2'b10);
    endtask

    // Read burst: every beat compared against the model, including during r_ready stalls.
    task automatic axi_read(input logic [31:0] addr, input int len, input logic [3:0] id,
                            input logic [1:0] burst, input logic [2:0] size,
                            input int stall_beat, input int stall_cyc);
        logic berr, ok, bok;
        logic [31:0] a;
        logic [70:0] exp;
        rd_data_q.delete();
        rd_resp_q.delete();
        berr = (burst != INCR) || (size != 3'd3);
        req.ar = '0;
        req.ar.addr = addr;
        req.ar.len = 8'(len);
        req.ar.id = id;
        req.ar.burst = burst;
        req.ar.size = size;
        req.ar_valid = 1'b1;
        wait_sig(3, "ar_ready", ok);
        if (!ok) begin req.ar_valid = 1'b0; return; end
        step();
        req.ar_valid = 1'b0;
        chk("ar_to_r_valid", {res.r_valid, res.ar_ready, busy}, 3'b101);
        for (int i = 0; i <= len; i++) begin
            a = addr + 32'(i * 8);
            bok = !berr && in_rng(a);
            exp = {id, bok ? mdl[widx(a)] : 64'h0, bok ? OKAY : SLVERR, i == len};
            if (i == stall_beat) begin
                for (int k = 0; k < stall_cyc; k++) begin
                    req.r_ready = 1'b0;
                    chk("r_stall_stable", {res.r_valid, res.ar_ready, res.r.id, res.r.data, res.r.resp, res.r.last},
                        {2'b10, exp});
                    step();
                end
            end
            req.r_ready = 1'b1;
            wait_sig(4, "r_valid", ok);
            if (!ok) begin req.r_ready = 1'b0; return; end
            chk("r_beat", {res.r.id, res.r.data, res.r.resp, res.r.last}, exp);
            rd_data_q.push_back(res.r.data);
            rd_resp_q.push_back(res.r.resp);
            step();
            req.r_ready = 1'b0;
        end
        chk("ar_ready_after_last", {res.ar_ready, res.r_valid}, 2'b10);
    endtask

    logic [1:0]  bresp;
    logic [63:0] tp_pat [4];
    logic [63:0] oldv, newv;

    initial begin
        req = '0;
        rst = 1'b1;
        vecs[0]  = '{32'h8, INCR, 3'd3, 6'd0, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, OKAY, 32'h8, INCR, 64'hFFFF_FFFF_FFFF_FFFF, OKAY};
        vecs[1]  = '{32'h8, INCR, 3'd3, 6'd0, 64'h0, 8'h0F, OKAY, 32'h8, INCR, 64'hFFFF_FFFF_0000_0000, OKAY};
        vecs[2]  = '{32'h8, FIXED, 3'd3, 6'd0, 64'h1234, 8'hFF, SLVERR, 32'h8, INCR, 64'hFFFF_FFFF_0000_0000, OKAY};
        vecs[3]  = '{32'h8, INCR, 3'd2, 6'd0, 64'h1234, 8'hFF, SLVERR, 32'h8, INCR, 64'hFFFF_FFFF_0000_0000, OKAY};
        vecs[4]  = '{32'h8, INCR, 3'd3, 6'h20, 64'h1234, 8'hFF, SLVERR, 32'h8, INCR, 64'hFFFF_FFFF_0000_0000, OKAY};
        vecs[5]  = '{32'h10, INCR, 3'd3, 6'd0, 64'h0123_4567_89AB_CDEF, 8'hFF, OKAY, 32'h10, INCR, 64'h0123_4567_89AB_CDEF, OKAY};
        vecs[6]  = '{32'h10, INCR, 3'd3, 6'd0, 64'hFEDC_BA98_7654_3210, 8'h81, OKAY, 32'h10, INCR, 64'hFE23_4567_89AB_CD10, OKAY};
        vecs[7]  = '{32'h10, INCR, 3'd3, 6'd0, 64'h0, 8'h00, OKAY, 32'h10, INCR, 64'hFE23_4567_89AB_CD10, OKAY};
        vecs[8]  = '{32'h2000, INCR, 3'd3, 6'd0, 64'h77, 8'hFF, SLVERR, 32'h2000, INCR, 64'h0, SLVERR};
        vecs[9]  = '{32'h1FF8, INCR, 3'd3, 6'd0, 64'hCAFE_F00D_DEAD_BEEF, 8'hFF, OKAY, 32'h1FF8, INCR, 64'hCAFE_F00D_DEAD_BEEF, OKAY};
        vecs[10] = '{32'h8000_1FF8, INCR, 3'd3, 6'd0, 64'h1, 8'hFF, SLVERR, 32'h1FF8, INCR, 64'hCAFE_F00D_DEAD_BEEF, OKAY};
        vecs[11] = '{32'h18, INCR, 3'd3, 6'd0, 64'h5555_5555_5555_5555, 8'hFF, OKAY, 32'h18, FIXED, 64'h0, SLVERR};
        tp_pat[0] = 64'h1111_1111_1111_1111;
        tp_pat[1] = 64'h2222_2222_2222_2222;
        tp_pat[2] = 64'h3333_3333_3333_3333;
        tp_pat[3] = 64'h4444_4444_4444_4444;

        // Reset behaviour
        repeat (3) step();
        chk("reset_hold", {res.aw_ready, res.w_ready, res.b_valid, res.ar_ready, res.r_valid, busy}, 6'b0);
        rst = 1'b0;
        #1;
        chk("reset_release", {res.aw_ready, res.w_ready, res.b_valid, res.ar_ready, res.r_valid, busy}, 6'b100100);
        step();

        // Fill storage so the model knows every word
        for (int blk = 0; blk < 4; blk++) begin
            wdata_q.delete();
            wstrb_q.delete();
            for (int i = 0; i < 256; i++) begin
                wdata_q.push_back({$urandom, $urandom});
                wstrb_q.push_back(8'hFF);
            end
            axi_write(32'(blk * 2048), 255, 4'(blk), INCR, 3'd3, 6'd0, 256, 0, bresp);
            chk("init_b", bresp, OKAY);
        end

        // Directed single-beat vectors
        for (int v = 0; v < 12; v++) begin
            wdata_q = '{vecs[v].wdata};
            wstrb_q = '{vecs[v].wstrb};
            axi_write(vecs[v].waddr, 0, 4'(v), vecs[v].wburst, vecs[v].wsize, vecs[v].watop, 1, 0, bresp);
            chk("vec_bresp", bresp, vecs[v].exp_b);
            axi_read(vecs[v].raddr, 0, 4'(v), vecs[v].rburst, 3'd3, 1, 0);
            if (rd_data_q.size() > 0)
                chk("vec_rdata", {rd_data_q[0], rd_resp_q[0]}, {vecs[v].exp_r, vecs[v].exp_rresp});
        end

        // Write four beats then read them back
        wdata_q = '{tp_pat[0], tp_pat[1], tp_pat[2], tp_pat[3]};
        wstrb_q = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
        axi_write(32'h0, 3, 4'd2, INCR, 3'd3, 6'd0, 4, 0, bresp);
        chk("wr4_bresp", bresp, OKAY);
        axi_read(32'h0, 3, 4'd2, INCR, 3'd3, 9, 0);
        for (int i = 0; i < 4; i++)
            if (rd_data_q.size() > i) chk("rd4_data", rd_data_q[i], tp_pat[i]);

        // Read crossing the top of storage
        axi_read(32'h1FF8, 1, 4'd9, INCR, 3'd3, 9, 0);
        if (rd_resp_q.size() == 2)
            chk("top_cross", {rd_resp_q[0], rd_resp_q[1], rd_data_q[1]}, {OKAY, SLVERR, 64'h0});

        // Backpressure on R mid-burst and on B
        axi_read(32'h0, 3, 4'd7, INCR, 3'd3, 2, 5);
        wdata_q = '{64'hA5A5_0000_0000_5A5A, 64'h0F0F_F0F0_0F0F_F0F0};
        wstrb_q = '{8'hFF, 8'hFF};
        axi_write(32'h40, 1, 4'd3, INCR, 3'd3, 6'd0, 2, 3, bresp);
        chk("bp_bresp", bresp, OKAY);

        // Read and write of word 4 in the same cycle
        req.ar = '0;
        req.ar.addr = 32'h20;
        req.ar.id = 4'd5;
        req.ar.burst = INCR;
        req.ar.size = 3'd3;
        req.aw = '0;
        req.aw.addr = 32'h20;
        req.aw.id = 4'd6;
        req.aw.burst = INCR;
        req.aw.size = 3'd3;
        req.ar_valid = 1'b1;
        req.aw_valid = 1'b1;
        chk("col_readies", {res.ar_ready, res.aw_ready}, 2'b11);
        step();
        req.ar_valid = 1'b0;
        req.aw_valid = 1'b0;
        oldv = mdl[4];
        newv = {$urandom, $urandom};
        req.w = '0;
        req.w.data = newv;
        req.w.strb = 8'hFF;
        req.w.last = 1'b1;
        req.w_valid = 1'b1;
        req.r_ready = 1'b1;
        chk("col_both_active", {res.r_valid, res.w_ready}, 2'b11);
        chk("col_old_data", {res.r.data, res.r.resp, res.r.last}, {oldv, OKAY, 1'b1});
        step();
        req.w_valid = 1'b0;
        req.r_ready = 1'b0;
        mdl[4] = newv;
        req.b_ready = 1'b1;
        chk("col_b", {res.b_valid, res.b.id, res.b.resp}, {1'b1, 4'd6, OKAY});
        step();
        req.b_ready = 1'b0;
        axi_read(32'h20, 0, 4'd5, INCR, 3'd3, 9, 0);
        if (rd_data_q.size() > 0) chk("col_new_data", rd_data_q[0], newv);

        // Reset after two of four W beats
        req.aw = '0;
        req.aw.addr = 32'h100;
        req.aw.len = 8'd3;
        req.aw.id = 4'd1;
        req.aw.burst = INCR;
        req.aw.size = 3'd3;
        req.aw_valid = 1'b1;
        step();
        req.aw_valid = 1'b0;
        wdata_q = '{{$urandom, $urandom}, {$urandom, $urandom}};
        for (int k = 0; k < 2; k++) begin
            req.w = '0;
            req.w.data = wdata_q[k];
            req.w.strb = 8'hFF;
            req.w_valid = 1'b1;
            chk("rst_w_ready", res.w_ready, 1'b1);
            step();
        end
        req.w_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_mid_hold", {res.aw_ready, res.w_ready, res.b_valid, res.ar_ready, res.r_valid, busy}, 6'b0);
        step();
        rst = 1'b0;
        #1;
        chk("rst_mid_release", {res.aw_ready, res.w_ready, res.b_valid, res.ar_ready, res.r_valid, busy}, 6'b100100);
        mdl[32] = wdata_q[0];
        mdl[33] = wdata_q[1];
        for (int k = 0; k < 3; k++) begin
            step();
            chk("rst_no_b", res.b_valid, 1'b0);
        end
        axi_read(32'h100, 3, 4'd1, INCR, 3'd3, 9, 0);

        // Randomized bursts against the model
        for (int t = 0; t < 60; t++) begin
            int word, len, nb, r;
            logic [3:0] id;
            logic [1:0] burst;
            logic [2:0] size;
            logic [5:0] atop;
            word = int'($urandom_range(0, MemWords - 1));
            if ($urandom_range(0, 3) == 0) word = int'(MemWords) - int'($urandom_range(0, 5));
            len = int'($urandom_range(0, 7));
            id = 4'($urandom);
            burst = ($urandom_range(0, 9) == 0) ? FIXED : INCR;
            size = ($urandom_range(0, 9) == 0) ? 3'd2 : 3'd3;
            if ($urandom_range(0, 1) == 1) begin
                atop = ($urandom_range(0, 9) == 0) ? 6'h21 : 6'd0;
                nb = len + 1;
                r = int'($urandom_range(0, 9));
                if (r == 0 && len > 0) nb = len;
                else if (r == 1) nb = len + 2;
                wdata_q.delete();
                wstrb_q.delete();
                for (int i = 0; i < nb; i++) begin
                    wdata_q.push_back({$urandom, $urandom});
                    wstrb_q.push_back(($urandom_range(0, 1) == 1) ? 8'hFF : 8'($urandom));
                end
                axi_write(32'(word * 8), len, id, burst, size, atop, nb, int'($urandom_range(0, 3)), bresp);
            end else begin
                axi_read(32'(word * 8), len, id, burst, size,
                         int'($urandom_range(0, len)), int'($urandom_range(0, 3)));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
